// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, handshakes with instruction memory, presents one instruction to decode.
// Optional zero-word halt detection enabled by defining FETCH_HALT_DETECT_EN.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {S_REQ, S_VALID, S_HALT, S_FAULT} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        pc_bad_c;
  logic        redir_hit_c;
  logic        halt_word_c;

  assign pc_bad_c    = (pc[1:0] != 2'b00) || (pc > LAST_PC);
  assign redir_hit_c = pend || redirect_valid;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_word_c = (mem_rdata == 32'h0000_0000);
`else
  assign halt_word_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ: begin
        if (pc_bad_c)                       state_nx = S_FAULT;
        else if (mem_ready && !redir_hit_c) state_nx = halt_word_c ? S_HALT : S_VALID;
      end
      S_VALID: begin
        if (redirect_valid || !stall) state_nx = S_REQ;
      end
      default: state_nx = state;
    endcase
  end

  // PC, pending-redirect and instruction registers; a newer redirect always wins
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_pc   <= 32'h0000_0000;
      inst_q    <= 32'h0000_0000;
      inst_pc_q <= 32'h0000_0000;
    end else begin
      case (state)
        S_REQ: begin
          if (!pc_bad_c) begin
            if (mem_ready) begin
              if (redir_hit_c) begin
                pc   <= redirect_valid ? redirect_pc : pend_pc;
                pend <= 1'b0;
              end else if (!halt_word_c) begin
                inst_q    <= mem_rdata;
                inst_pc_q <= pc;
              end
            end else if (redirect_valid) begin
              pend    <= 1'b1;
              pend_pc <= redirect_pc;
            end
          end
        end
        S_VALID: begin
          if (redirect_valid) pc <= redirect_pc;
          else if (!stall)    pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // Output decode; everything reads 0 while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = 32'h0000_0000;
    inst_valid = 1'b0;
    inst       = 32'h0000_0000;
    inst_pc    = 32'h0000_0000;
    halted     = 1'b0;
    fault      = 1'b0;
    if (!reset) begin
      mem_addr = pc;
      inst     = inst_q;
      inst_pc  = inst_pc_q;
      case (state)
        S_REQ:   mem_req    = !pc_bad_c;
        S_VALID: inst_valid = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
        S_HALT:  halted     = 1'b1;
`endif
        S_FAULT: fault      = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the MIPS core. Owns the program counter, drives a byte-addressed, big-endian, variable-latency instruction memory port through a req/ready handshake, and presents one instruction at a time to decode. Handles stalls, branch/jump redirects (including redirects that arrive while a fetch is in flight), end-of-program halt, and illegal fetch addresses. Sits between the PC-update logic of the datapath and the instruction memory.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- MEM_BYTES, 256: instruction memory size in bytes; legal fetch PCs are 0 .. MEM_BYTES-4.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept the presented instruction this cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC for the redirect.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  32  byte address of the fetch; equals pc.
- mem_ready  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  fetched word, {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- inst_valid  out  1  inst and inst_pc are valid.
- inst  out  32  instruction presented to decode.
- inst_pc  out  32  PC of inst.
- halted  out  1  end of program reached; sticky until reset.
- fault  out  1  illegal fetch PC; sticky until reset.

## Operation
- States: REQ, VALID, HALT, FAULT. Reset state is REQ, with pc = RESET_PC.
- Reset values:
  - all outputs are 0 while reset is high;
  - the internal registers are pc = RESET_PC, pend = 0, inst = 0, inst_pc = 0.
- REQ:
  - If pc[1:0] != 0 or pc > MEM_BYTES-4: mem_req = 0, go to FAULT.
  - Otherwise mem_req = 1 and mem_addr = pc, both held stable until mem_ready.
  - redirect_valid in REQ sets pend = 1 and pend_pc = redirect_pc. A later redirect overwrites pend_pc.
  - On mem_ready with pend set, or with redirect_valid in the same cycle: discard the word, load pc from the newest target, clear pend, and stay in REQ.
  - Otherwise on mem_ready: inst <= mem_rdata, inst_pc <= pc, go to VALID.
- VALID: inst_valid = 1 and mem_req = 0.
  - redirect_valid: drop inst, pc <= redirect_pc, go to REQ. Redirect takes priority over stall.
  - Else if !stall: the instruction is accepted, pc <= pc + 4 (32-bit wrap), go to REQ.
  - Else: hold; inst and inst_pc are unchanged.
- HALT: halted = 1; mem_req = 0; inst_valid = 0. Ignores all inputs except reset.
- FAULT: fault = 1; otherwise behaves as HALT.
- Reset in any state, including mid-fetch, returns to REQ with pc = RESET_PC and drops any pending redirect. Memory must tolerate an abandoned request.

## Timing
- mem_ready in cycle N gives inst_valid in cycle N+1.
- Acceptance in cycle M gives mem_req for pc+4 in cycle M+1.
- Minimum cycles per instruction = 2 + memory wait cycles. With mem_ready returned in the request cycle, this is one instruction every 2 cycles.
- Redirect in VALID in cycle M gives mem_req with mem_addr = redirect_pc in cycle M+1.
- Redirect in REQ costs the remainder of the in-flight fetch. The new request is issued the cycle after mem_ready.
- halted and fault assert in the cycle after the triggering event.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - In REQ, mem_ready with mem_rdata == 32'h0000_0000 and no pending or same-cycle redirect goes to HALT.
  - The zero word is never presented (inst_valid stays 0).
- FETCH_HALT_DETECT_EN undefined:
  - The zero word is presented as a normal instruction (sll $0,$0,0, i.e. NOP).
  - halted is tied to 0 and HALT is unreachable.

## Test plan
- Reset, memory with 0-wait mem_ready, words 0x20080005, 0x20090003, then 0: inst_valid with inst_pc 0 then 4, one instruction every 2 cycles. With FETCH_HALT_DETECT_EN, halted = 1 after the fetch at PC 8 and no third inst_valid. Without it, the third inst = 0 with inst_pc = 8.
- stall held 3 cycles while inst_pc = 4: inst is unchanged and mem_req = 0 throughout. After stall drops, the next mem_addr is 8.
- Redirect in VALID to 0x40 while stalled: next cycle mem_req = 1 with mem_addr = 0x40, and the stalled instruction is never accepted.
- Memory with 3 wait cycles, redirect to 0x20 in the second wait cycle: the word returned for the old PC is discarded, the next mem_addr is 0x20, and the next inst_pc is 0x20.
- Redirect to 0x42 gives fault = 1 with no mem_req. Separately, with MEM_BYTES = 256, sequential fetch reaching PC 0x100 gives fault = 1.
- Reset asserted mid-fetch (mem_req high, no mem_ready): next cycle all outputs are 0. The cycle after reset releases, mem_addr = RESET_PC and pend is cleared.
